// File: rtl/operand_stager_pkg.sv
// Shared types and constants for the OP-stage operand stager and its
// per-source forwarding selectors.
package operand_stager_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } op_state;

  localparam logic [4:0] X0_ADDR = 5'd0;

endpackage

// File: rtl/operand_stager_fwd_sel.sv
// Resolves one source operand against the own output slot and the
// downstream producer stages, youngest match first.
module operand_fwd_sel
  import operand_stager_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NFWD = 3
) (
  input  logic [4:0]           src_addr,
  input  logic                 src_use,
  input  logic [XLEN-1:0]      rf_val,
  input  logic                 slot_valid,
  input  logic [4:0]           slot_rd,
  input  logic                 slot_wr,
  input  logic [NFWD*5-1:0]    stg_rd,
  input  logic [NFWD-1:0]      stg_wr,
  input  logic [NFWD-1:0]      stg_rdy,
  input  logic [NFWD*XLEN-1:0] stg_val,
  output logic [XLEN-1:0]      val,
  output logic                 hazard
);

  logic found;

  // The own slot is younger than every stage, and its result does not exist yet,
  // so a match there is always a stall regardless of what the stages hold.
  always_comb begin
    val    = rf_val;
    hazard = 1'b0;
    found  = 1'b0;
    if (!src_use || src_addr == X0_ADDR) begin
      val = '0;
    end else begin
      if (slot_valid && slot_wr && slot_rd == src_addr) begin
        found  = 1'b1;
        hazard = 1'b1;
      end
      for (int i = 0; i < NFWD; i++) begin
        if (!found && stg_wr[i] && stg_rd[i*5 +: 5] == src_addr) begin
          found = 1'b1;
          if (stg_rdy[i]) begin
            val = stg_val[i*XLEN +: XLEN];
          end else begin
            hazard = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/operand_stager.sv
// OP-stage operand preparer: forwards or stalls each source, drains the
// pipeline for fix-marked instructions, and holds results in a valid/ready slot.
module operand_stager
  import operand_stager_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NFWD = 3,
  parameter int CNTW = 8
) (
  input  logic                 s_clk_i,
  input  logic                 s_resetn_i,
  input  logic                 s_in_valid_i,
  output logic                 s_in_ready_o,
  input  logic [4:0]           s_rs1_i,
  input  logic [4:0]           s_rs2_i,
  input  logic                 s_rs1_use_i,
  input  logic                 s_rs2_use_i,
  input  logic [4:0]           s_rd_i,
  input  logic                 s_wr_i,
  input  logic [XLEN-1:0]      s_rf_p1_i,
  input  logic [XLEN-1:0]      s_rf_p2_i,
  input  logic [XLEN-1:0]      s_imm_i,
  input  logic                 s_op2_imm_i,
  input  logic                 s_lsu_i,
  input  logic                 s_fix_i,
  input  logic [NFWD*5-1:0]    s_stg_rd_i,
  input  logic [NFWD-1:0]      s_stg_wr_i,
  input  logic [NFWD-1:0]      s_stg_rdy_i,
  input  logic [NFWD*XLEN-1:0] s_stg_val_i,
  input  logic [NFWD-1:0]      s_stg_busy_i,
  input  logic                 s_flush_i,
  output logic                 s_out_valid_o,
  input  logic                 s_out_ready_i,
  output logic [XLEN-1:0]      s_op1_o,
  output logic [XLEN-1:0]      s_op2_o,
  output logic                 s_hazard_o,
  output logic [CNTW-1:0]      s_stall_cnt_o
);

  op_state         state;
  logic [4:0]      held_rd;
  logic            held_wr;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic            rs1_haz;
  logic            rs2_haz;
  logic            pipe_empty;
  logic            fix_wait;
  logic            state_ok;
  logic            accept;
  logic [XLEN-1:0] op1_next;
  logic [XLEN-1:0] op2_next;

  operand_fwd_sel #(.XLEN(XLEN), .NFWD(NFWD)) u_fwd_rs1 (
    .src_addr   (s_rs1_i),
    .src_use    (s_rs1_use_i),
    .rf_val     (s_rf_p1_i),
    .slot_valid (s_out_valid_o),
    .slot_rd    (held_rd),
    .slot_wr    (held_wr),
    .stg_rd     (s_stg_rd_i),
    .stg_wr     (s_stg_wr_i),
    .stg_rdy    (s_stg_rdy_i),
    .stg_val    (s_stg_val_i),
    .val        (rs1_val),
    .hazard     (rs1_haz)
  );

  operand_fwd_sel #(.XLEN(XLEN), .NFWD(NFWD)) u_fwd_rs2 (
    .src_addr   (s_rs2_i),
    .src_use    (s_rs2_use_i),
    .rf_val     (s_rf_p2_i),
    .slot_valid (s_out_valid_o),
    .slot_rd    (held_rd),
    .slot_wr    (held_wr),
    .stg_rd     (s_stg_rd_i),
    .stg_wr     (s_stg_wr_i),
    .stg_rdy    (s_stg_rdy_i),
    .stg_val    (s_stg_val_i),
    .val        (rs2_val),
    .hazard     (rs2_haz)
  );

  // A fix instruction may only enter once nothing downstream or in our own slot is in flight.
  assign pipe_empty   = ~(|s_stg_busy_i) & ~s_out_valid_o;
  assign fix_wait     = s_in_valid_i & s_fix_i & ~pipe_empty;
  assign state_ok     = (state == DRAIN) ? pipe_empty : ~fix_wait;
  assign s_hazard_o   = s_in_valid_i & (rs1_haz | rs2_haz);
  assign s_in_ready_o = s_resetn_i & state_ok & ~s_hazard_o & (~s_out_valid_o | s_out_ready_i);
  assign accept       = s_in_valid_i & s_in_ready_o;
  assign op1_next     = s_lsu_i ? rs1_val + s_imm_i : rs1_val;
  assign op2_next     = s_op2_imm_i ? s_imm_i : rs2_val;

  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) begin
      state <= RUN;
    end else if (s_flush_i) begin
      state <= RUN;
    end else begin
      case (state)
        RUN:     if (fix_wait) state <= DRAIN;
        DRAIN:   if (pipe_empty) state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  // Flush wins over a same-cycle acceptance; op values simply stay stale behind out_valid=0.
  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) begin
      s_out_valid_o <= 1'b0;
      s_op1_o       <= '0;
      s_op2_o       <= '0;
      held_rd       <= '0;
      held_wr       <= 1'b0;
    end else if (s_flush_i) begin
      s_out_valid_o <= 1'b0;
      held_wr       <= 1'b0;
    end else if (accept) begin
      s_out_valid_o <= 1'b1;
      s_op1_o       <= op1_next;
      s_op2_o       <= op2_next;
      held_rd       <= s_rd_i;
      held_wr       <= s_wr_i;
    end else if (s_out_valid_o && s_out_ready_i) begin
      s_out_valid_o <= 1'b0;
    end
  end

  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) begin
      s_stall_cnt_o <= '0;
    end else if (s_flush_i || accept) begin
      s_stall_cnt_o <= '0;
    end else if (s_in_valid_i && s_stall_cnt_o != '1) begin
      s_stall_cnt_o <= s_stall_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_operand_stager.sv
// Directed plus randomized bench for operand_stager, checked against a
// queue/struct based reference model of forwarding, draining and the output slot.
module tb_operand_stager;

  localparam int XLEN = 32;
  localparam int NFWD = 3;
  localparam int CNTW = 8;

  logic                 s_clk_i = 1'b0;
  logic                 s_resetn_i;
  logic                 s_in_valid_i;
  logic                 s_in_ready_o;
  logic [4:0]           s_rs1_i, s_rs2_i, s_rd_i;
  logic                 s_rs1_use_i, s_rs2_use_i, s_wr_i;
  logic [XLEN-1:0]      s_rf_p1_i, s_rf_p2_i, s_imm_i;
  logic                 s_op2_imm_i, s_lsu_i, s_fix_i, s_flush_i;
  logic [NFWD*5-1:0]    s_stg_rd_i;
  logic [NFWD-1:0]      s_stg_wr_i, s_stg_rdy_i, s_stg_busy_i;
  logic [NFWD*XLEN-1:0] s_stg_val_i;
  logic                 s_out_valid_o, s_out_ready_i, s_hazard_o;
  logic [XLEN-1:0]      s_op1_o, s_op2_o;
  logic [CNTW-1:0]      s_stall_cnt_o;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: the one instruction parked for EX and a drain flag.
  bit              m_valid, m_drain, m_wr;
  logic [4:0]      m_rd;
  logic [XLEN-1:0] m_op1, m_op2;
  int unsigned     m_cnt;
  logic            pre_ready, pre_hazard;
  logic [XLEN-1:0] held_op1;

  typedef struct {
    logic [4:0]      rd;
    logic            wr;
    logic            rdy;
    logic [XLEN-1:0] val;
  } cand_t;

  operand_stager #(.XLEN(XLEN), .NFWD(NFWD), .CNTW(CNTW)) dut (
    .s_clk_i(s_clk_i), .s_resetn_i(s_resetn_i),
    .s_in_valid_i(s_in_valid_i), .s_in_ready_o(s_in_ready_o),
    .s_rs1_i(s_rs1_i), .s_rs2_i(s_rs2_i),
    .s_rs1_use_i(s_rs1_use_i), .s_rs2_use_i(s_rs2_use_i),
    .s_rd_i(s_rd_i), .s_wr_i(s_wr_i),
    .s_rf_p1_i(s_rf_p1_i), .s_rf_p2_i(s_rf_p2_i), .s_imm_i(s_imm_i),
    .s_op2_imm_i(s_op2_imm_i), .s_lsu_i(s_lsu_i), .s_fix_i(s_fix_i),
    .s_stg_rd_i(s_stg_rd_i), .s_stg_wr_i(s_stg_wr_i), .s_stg_rdy_i(s_stg_rdy_i),
    .s_stg_val_i(s_stg_val_i), .s_stg_busy_i(s_stg_busy_i), .s_flush_i(s_flush_i),
    .s_out_valid_o(s_out_valid_o), .s_out_ready_i(s_out_ready_i),
    .s_op1_o(s_op1_o), .s_op2_o(s_op2_o),
    .s_hazard_o(s_hazard_o), .s_stall_cnt_o(s_stall_cnt_o)
  );

  always #5 s_clk_i = ~s_clk_i;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Youngest matching producer decides; candidates listed youngest first.
  function automatic void resolve(input logic [4:0] addr, input logic use_src, input logic [XLEN-1:0] rf,
                                  output logic [XLEN-1:0] v, output logic haz);
    cand_t cands[NFWD+1];
    bit found;
    v = rf;
    haz = 1'b0;
    found = 0;
    if (!use_src || addr == 5'd0) begin
      v = '0;
      return;
    end
    cands[0].rd = m_rd; cands[0].wr = m_valid && m_wr; cands[0].rdy = 1'b0; cands[0].val = '0;
    for (int i = 0; i < NFWD; i++) begin
      cands[i+1].rd  = s_stg_rd_i[i*5 +: 5];
      cands[i+1].wr  = s_stg_wr_i[i];
      cands[i+1].rdy = s_stg_rdy_i[i];
      cands[i+1].val = s_stg_val_i[i*XLEN +: XLEN];
    end
    for (int i = 0; i <= NFWD; i++) begin
      if (!found && cands[i].wr && cands[i].rd == addr) begin
        found = 1;
        if (cands[i].rdy) v = cands[i].val;
        else haz = 1'b1;
      end
    end
  endfunction

  task automatic modelReset();
    m_valid = 0; m_drain = 0; m_wr = 0; m_rd = '0;
    m_op1 = '0; m_op2 = '0; m_cnt = 0;
  endtask

  // One clock: check combinational outputs, advance the model at the edge, check registers.
  task automatic applyStimulus();
    logic [XLEN-1:0] v1, v2;
    logic h1, h2, hz, empty, gate, rdy, acc;
    #1;
    resolve(s_rs1_i, s_rs1_use_i, s_rf_p1_i, v1, h1);
    resolve(s_rs2_i, s_rs2_use_i, s_rf_p2_i, v2, h2);
    hz    = s_in_valid_i & (h1 | h2);
    empty = (s_stg_busy_i == '0) && !m_valid;
    gate  = m_drain ? empty : !(s_in_valid_i && s_fix_i && !empty);
    rdy   = s_resetn_i & gate & !hz & (!m_valid | s_out_ready_i);
    acc   = s_in_valid_i & rdy;
    pre_ready  = s_in_ready_o;
    pre_hazard = s_hazard_o;
    checkOutput("in_ready", {63'd0, s_in_ready_o}, {63'd0, rdy});
    checkOutput("hazard", {63'd0, s_hazard_o}, {63'd0, hz});
    @(posedge s_clk_i);
    if (!s_resetn_i) begin
      modelReset();
    end else if (s_flush_i) begin
      m_valid = 0; m_drain = 0; m_cnt = 0;
    end else begin
      m_drain = m_drain ? !empty : (s_in_valid_i && s_fix_i && !empty);
      if (acc) begin
        m_valid = 1;
        m_op1 = s_lsu_i ? XLEN'(v1 + s_imm_i) : v1;
        m_op2 = s_op2_imm_i ? s_imm_i : v2;
        m_rd = s_rd_i; m_wr = s_wr_i; m_cnt = 0;
      end else begin
        if (m_valid && s_out_ready_i) m_valid = 0;
        if (s_in_valid_i && m_cnt < 255) m_cnt++;
      end
    end
    #1;
    checkOutput("out_valid", {63'd0, s_out_valid_o}, {63'd0, m_valid});
    checkOutput("op1", {32'd0, s_op1_o}, {32'd0, m_op1});
    checkOutput("op2", {32'd0, s_op2_o}, {32'd0, m_op2});
    checkOutput("stall_cnt", {56'd0, s_stall_cnt_o}, 64'(m_cnt));
    @(negedge s_clk_i);
  endtask

  task automatic idleInputs();
    s_in_valid_i = 0; s_rs1_i = 0; s_rs2_i = 0; s_rs1_use_i = 0; s_rs2_use_i = 0;
    s_rd_i = 0; s_wr_i = 0; s_rf_p1_i = 0; s_rf_p2_i = 0; s_imm_i = 0;
    s_op2_imm_i = 0; s_lsu_i = 0; s_fix_i = 0; s_flush_i = 0; s_out_ready_i = 1;
    s_stg_rd_i = '0; s_stg_wr_i = '0; s_stg_rdy_i = '0; s_stg_val_i = '0; s_stg_busy_i = '0;
  endtask

  task automatic doReset();
    s_resetn_i = 0;
    modelReset();
    repeat (2) applyStimulus();
    s_resetn_i = 1;
  endtask

  initial begin
    idleInputs();
    doReset();
    checkOutput("rst_out_valid", {63'd0, s_out_valid_o}, 64'd0);
    checkOutput("rst_in_ready", {63'd0, pre_ready}, 64'd0);

    // No dependency: add x3,x1,x2
    s_in_valid_i = 1; s_rs1_i = 1; s_rs2_i = 2; s_rs1_use_i = 1; s_rs2_use_i = 1;
    s_rd_i = 3; s_wr_i = 1; s_rf_p1_i = 5; s_rf_p2_i = 7;
    applyStimulus();
    checkOutput("t1_op1", {32'd0, s_op1_o}, 64'd5);
    checkOutput("t1_op2", {32'd0, s_op2_o}, 64'd7);
    checkOutput("t1_cnt", {56'd0, s_stall_cnt_o}, 64'd0);

    // Youngest stage wins
    s_rd_i = 8;
    s_stg_rd_i = {5'd0, 5'd1, 5'd1}; s_stg_wr_i = 3'b011; s_stg_rdy_i = 3'b011;
    s_stg_val_i = {32'd0, 32'h10, 32'h20};
    applyStimulus();
    checkOutput("t2_op1", {32'd0, s_op1_o}, 64'h20);

    // Own-slot hazard, then forward from stage 0
    s_stg_wr_i = '0; s_stg_rdy_i = '0;
    s_rs1_i = 5; s_rs2_i = 6; s_rd_i = 1;
    applyStimulus();
    s_rs1_i = 1; s_rs2_i = 2; s_rd_i = 7;
    applyStimulus();
    checkOutput("t3_hazard", {63'd0, pre_hazard}, 64'd1);
    checkOutput("t3_cnt", {56'd0, s_stall_cnt_o}, 64'd1);
    s_stg_rd_i = {10'd0, 5'd1}; s_stg_wr_i = 3'b001; s_stg_rdy_i = 3'b001; s_stg_val_i = {64'd0, 32'h55};
    applyStimulus();
    checkOutput("t3_op1", {32'd0, s_op1_o}, 64'h55);

    // Load-use
    s_stg_rd_i = {10'd0, 5'd4}; s_stg_rdy_i = 3'b000; s_stg_val_i = '0;
    s_rs1_i = 4; s_rs2_use_i = 0; s_lsu_i = 1; s_imm_i = 32'hFFFF_FFFC; s_rd_i = 10;
    repeat (3) applyStimulus();
    checkOutput("t4_cnt", {56'd0, s_stall_cnt_o}, 64'd3);
    s_stg_rdy_i = 3'b001; s_stg_val_i = {64'd0, 32'h100};
    applyStimulus();
    checkOutput("t4_op1", {32'd0, s_op1_o}, 64'hFC);

    // Fix drain
    idleInputs();
    s_in_valid_i = 1; s_fix_i = 1; s_stg_busy_i = 3'b011;
    applyStimulus();
    checkOutput("t5_ready0", {63'd0, pre_ready}, 64'd0);
    applyStimulus();
    s_stg_busy_i = 3'b000;
    applyStimulus();
    checkOutput("t5_ready1", {63'd0, pre_ready}, 64'd1);
    checkOutput("t5_valid", {63'd0, s_out_valid_o}, 64'd1);

    // Reset while draining returns to RUN
    s_stg_busy_i = 3'b011;
    applyStimulus();
    doReset();
    s_fix_i = 0;
    applyStimulus();
    checkOutput("t6_ready", {63'd0, pre_ready}, 64'd1);

    // Back-pressure hold, then flush against an acceptance
    idleInputs();
    s_in_valid_i = 1; s_rs1_i = 11; s_rs1_use_i = 1; s_rf_p1_i = 32'hAAAA;
    applyStimulus();
    held_op1 = s_op1_o;
    s_out_ready_i = 0; s_rf_p1_i = 32'hBBBB;
    for (int i = 0; i < 4; i++) begin
      applyStimulus();
      checkOutput("t7_hold", {32'd0, s_op1_o}, {32'd0, held_op1});
    end
    s_out_ready_i = 1; s_flush_i = 1;
    applyStimulus();
    checkOutput("t7_flush_valid", {63'd0, s_out_valid_o}, 64'd0);
    checkOutput("t7_flush_cnt", {56'd0, s_stall_cnt_o}, 64'd0);
    s_flush_i = 0;

    // Saturation
    s_stg_rd_i = {10'd0, 5'd9}; s_stg_wr_i = 3'b001; s_stg_rdy_i = 3'b000; s_rs1_i = 9;
    repeat (300) applyStimulus();
    checkOutput("t8_sat", {56'd0, s_stall_cnt_o}, 64'd255);
    s_flush_i = 1;
    applyStimulus();

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      s_in_valid_i  = ($urandom_range(0, 3) != 0);
      s_rs1_i       = 5'($urandom_range(0, 4));
      s_rs2_i       = 5'($urandom_range(0, 4));
      s_rs1_use_i   = 1'($urandom);
      s_rs2_use_i   = 1'($urandom);
      s_rd_i        = 5'($urandom_range(0, 4));
      s_wr_i        = 1'($urandom);
      s_rf_p1_i     = $urandom;
      s_rf_p2_i     = $urandom;
      s_imm_i       = $urandom;
      s_op2_imm_i   = ($urandom_range(0, 3) == 0);
      s_lsu_i       = ($urandom_range(0, 3) == 0);
      s_fix_i       = ($urandom_range(0, 7) == 0);
      s_flush_i     = ($urandom_range(0, 15) == 0);
      s_out_ready_i = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NFWD; i++) s_stg_rd_i[i*5 +: 5] = 5'($urandom_range(0, 4));
      s_stg_wr_i    = 3'($urandom);
      s_stg_rdy_i   = 3'($urandom);
      s_stg_busy_i  = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'($urandom);
      s_stg_val_i   = {$urandom, $urandom, $urandom};
      applyStimulus();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
